rate_enable_gen: RTL and testbench
==================================

Name: rate_enable_gen

Overview:
- Programmable rate divider with run/pause control. It generates the one-cycle Enable strobe that drives the 8-bit T-flip-flop counter stage directly downstream.
- It converts the 50 MHz board clock into slow, human-visible count rates, selected by SW.
- A debounced-off-board KEY acts as a run/pause toggle.
- A synchronous clear returns the block to idle.

Parameters:
- CLK_HZ, 50_000_000, clock cycles per second. Benches override it to 8.
- CW, $clog2(4*CLK_HZ), down-counter width. Derived; do not override.

Ports:
- clock  input  1  system clock, all flops on rising edge
- resetn  input  1  asynchronous, active-low reset
- speed  input  2  rate select, asynchronous to clock (switches)
- run_btn  input  1  raw active-high run/pause request, asynchronous
- clear  input  1  synchronous clear, active-high, already in clock domain
- enable_out  output  1  one-cycle enable strobe to the downstream counter
- state  output  2  00 IDLE, 01 RUN, 10 PAUSE (11 never produced)
- count  output  CW  current down-counter value (debug/verification)

Behaviour:
- Reset (resetn=0, async):
  - state=IDLE, count=0, speed_q=00.
  - Synchronizer and edge flops = 0.
  - enable_out=0.
- speed input: passes through a 2-flop synchronizer before use.
- Load value L(s), computed from synchronized speed:
  - 00 -> 0 (strobe every cycle)
  - 01 -> CLK_HZ-1
  - 10 -> 2*CLK_HZ-1
  - 11 -> 4*CLK_HZ-1
  - Arithmetic is CW bits wide and never overflows.
- run_btn path:
  - 2-flop synchronizer (s1, s2), then s3 edge register.
  - press = s2 & ~s3.
  - State updates on the 3rd rising edge after run_btn rises, setup met.
  - Holding run_btn high produces one press only. Release is ignored.
- FSM:
  - IDLE: count <= L(speed) and speed_q <= speed every cycle. On press -> RUN.
  - RUN:
    - If count==0: count <= L(speed_q_new) and speed_q <= current synchronized speed (reload).
    - Otherwise count <= count-1.
    - On press -> PAUSE.
  - PAUSE: count and speed_q hold. On press -> RUN, resuming from the held count.
  - clear=1 in any state -> IDLE on the next edge, with count <= L(speed). Clear has priority over press.
- enable_out = (state==RUN) && (count==0). It is decoded from registered values only, with no combinational path from any input.
- Timing:
  - The strobe period in RUN is L+1 cycles.
  - The first strobe after IDLE->RUN comes L cycles after the first RUN cycle.
  - With speed=00, enable_out is high on every RUN cycle.
- Speed change: takes effect only at the next reload (count==0 in RUN) or while in IDLE. An interval in progress is never shortened or stretched.
- Press in the same cycle as count==0 in RUN:
  - The strobe is still issued that cycle.
  - count reloads and state -> PAUSE.
  - PAUSE then holds L.
- Clear in the same cycle as count==0 in RUN: the strobe is issued that cycle, and the next state is IDLE.
- Reset mid-interval: everything returns to reset values immediately. enable_out drops asynchronously.
- The count never wraps below 0. It is always reloaded at 0.

Test Plan (CLK_HZ=8, so CW=5):
- Reset then idle: resetn low 3 cycles, release, speed=01 -> state=00, count=7 from the 2nd edge after sync, enable_out never 1.
- Run at speed 01: pulse run_btn for 1 cycle -> state=01 on the 3rd edge; enable_out high exactly 1 cycle every 8 cycles, first strobe 7 cycles after entering RUN; 5 strobes in 40 cycles.
- Speed 00 and 11:
  - speed=00 in RUN -> enable_out continuously 1.
  - speed=11 -> strobe period 32 cycles.
  - Switching 01->11 mid-interval -> the current interval still ends on an 8-cycle boundary, and the next one is 32.
- Pause/resume:
  - Press when count=4 -> state=10, count holds 4 for 20 cycles, no strobes.
  - Press again -> state=01, strobe after exactly 4 more cycles.
- Priority and edge cases:
  - clear and press in the same cycle -> state=00.
  - Press coinciding with count==0 -> one strobe, then state=10 with count=7.
  - run_btn held high 50 cycles -> a single transition.
- Async reset mid-RUN at count=3 -> enable_out, state and count are 0 immediately, before the next edge.

Source files
------------

// File: rtl/rate_enable_gen_if.sv
// Control/status bundle for the rate enable generator: rate select, run/pause
// request and clear in; enable strobe, FSM state and down-counter value out.
interface rate_enable_gen_if #(
  parameter int CW = 28
);
  logic [1:0]    speed;
  logic          run_btn;
  logic          clear;
  logic          enable_out;
  logic [1:0]    state;
  logic [CW-1:0] count;

  modport master (
    output speed,
    output run_btn,
    output clear,
    input  enable_out,
    input  state,
    input  count
  );

  modport slave (
    input  speed,
    input  run_btn,
    input  clear,
    output enable_out,
    output state,
    output count
  );
endinterface

// File: rtl/rate_enable_gen.sv
// Programmable rate divider with run/pause control. Produces a one-cycle
// enable strobe for the downstream counter at a switch-selected slow rate.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | counter preloaded with L(speed) every cycle, no strobes
//   RUN   | counter runs down; strobe and reload when it reaches 0
//   PAUSE | counter and latched speed frozen; resume continues from it
//
// The bus count width must equal $clog2(4*CLK_HZ).
module rate_enable_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic             clock,
  input  logic             resetn,
  rate_enable_gen_if.slave bus
);

  localparam int CW = $clog2(4 * CLK_HZ);

  localparam logic [CW-1:0] LOAD_1 = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] LOAD_2 = CW'(2 * CLK_HZ - 1);
  localparam logic [CW-1:0] LOAD_4 = CW'(4 * CLK_HZ - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t        state_r;
  state_t        state_nx;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nx;
  logic [1:0]    speed_q;
  logic [1:0]    speed_q_nx;

  logic [1:0]    spd_s1;
  logic [1:0]    spd_s2;
  logic          btn_s1;
  logic          btn_s2;
  logic          btn_s3;
  logic          press;

  // Interval length minus one for each rate select.
  function automatic logic [CW-1:0] load_of(input logic [1:0] sel);
    case (sel)
      2'b00:   return '0;
      2'b01:   return LOAD_1;
      2'b10:   return LOAD_2;
      default: return LOAD_4;
    endcase
  endfunction

  // Bring the switch and button inputs into the clock domain; btn_s3 keeps
  // the previous synchronized level so a held button gives a single press.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      spd_s1 <= 2'b00;
      spd_s2 <= 2'b00;
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_s3 <= 1'b0;
    end else begin
      spd_s1 <= bus.speed;
      spd_s2 <= spd_s1;
      btn_s1 <= bus.run_btn;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
    end
  end

  assign press = btn_s2 & ~btn_s3;

  // FSM state, down-counter and latched rate select.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      count_r <= '0;
      speed_q <= 2'b00;
    end else begin
      state_r <= state_nx;
      count_r <= count_nx;
      speed_q <= speed_q_nx;
    end
  end

  // Next state and counter; clear overrides any press. Reloading only at
  // zero keeps a rate change from altering an interval already running.
  always_comb begin
    state_nx   = state_r;
    count_nx   = count_r;
    speed_q_nx = speed_q;
    if (bus.clear) begin
      state_nx   = IDLE;
      count_nx   = load_of(spd_s2);
      speed_q_nx = spd_s2;
    end else begin
      case (state_r)
        IDLE: begin
          count_nx   = load_of(spd_s2);
          speed_q_nx = spd_s2;
          if (press) state_nx = RUN;
        end
        RUN: begin
          if (count_r == '0) begin
            count_nx   = load_of(spd_s2);
            speed_q_nx = spd_s2;
          end else begin
            count_nx = count_r - ONE;
          end
          if (press) state_nx = PAUSE;
        end
        PAUSE: begin
          if (press) state_nx = RUN;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  // Strobe is decoded from registers only, so reset drops it immediately.
  assign bus.enable_out = (state_r == RUN) && (count_r == '0);
  assign bus.state      = state_r;
  assign bus.count      = count_r;

endmodule

// File: tb/tb_rate_enable_gen.sv
// Bench for rate_enable_gen at CLK_HZ=8 (5-bit counter). Expected strobe
// cycles are queued when stimulus is applied and compared against the
// strobe cycles recorded from the design.
module tb_rate_enable_gen;

  localparam int CLK_HZ = 8;
  localparam int CW     = 5;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  rate_enable_gen_if #(.CW(CW)) bus ();

  rate_enable_gen #(.CLK_HZ(CLK_HZ)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total  = 0;
  int passed = 0;
  bit mon_en = 1'b0;
  int exp_q[$];
  int obs_q[$];

  always @(negedge clock) begin
    if (resetn && mon_en && bus.enable_out) obs_q.push_back(cyc);
  end

  task automatic goto(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic pulse_btn();
    bus.run_btn = 1'b1;
    @(negedge clock);
    bus.run_btn = 1'b0;
  endtask

  task automatic do_reset(input logic [1:0] spd);
    mon_en = 1'b0;
    @(negedge clock);
    resetn      = 1'b0;
    bus.speed   = spd;
    bus.run_btn = 1'b0;
    bus.clear   = 1'b0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (4) @(negedge clock);
    exp_q.delete();
    obs_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    int r, e, o;
    mon_en = 1'b0;
    @(negedge clock);
    resetn = 1'b0; bus.speed = 2'b01; bus.run_btn = 1'b0; bus.clear = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (bus.state === 2'b00) passed++; else $display("FAIL reset_state: got %0d want 0", bus.state);
    total++; if (bus.count === 5'd0) passed++; else $display("FAIL reset_count: got %0d want 0", bus.count);
    total++; if (bus.enable_out === 1'b0) passed++; else $display("FAIL reset_enable: got %0d want 0", bus.enable_out);
    resetn = 1'b1;
    r = cyc;
    exp_q.delete(); obs_q.delete(); mon_en = 1'b1;
    goto(r + 3);
    total++; if (bus.state === 2'b00) passed++; else $display("FAIL idle_state: got %0d want 0", bus.state);
    total++; if (bus.count === 5'd7) passed++; else $display("FAIL idle_count: got %0d want 7", bus.count);
    goto(r + 13);
    total++; if (bus.count === 5'd7) passed++; else $display("FAIL idle_count_hold: got %0d want 7", bus.count);
    #1;
    total++; if (obs_q.size() == exp_q.size()) passed++; else $display("FAIL idle_strobes: got %0d want %0d", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o == e) passed++; else $display("FAIL idle_strobe_cycle: got %0d want %0d", o, e);
    end
    mon_en = 1'b0;
  endtask

  task automatic test_run_speed01();
    int n, e, o;
    do_reset(2'b01);
    n = cyc;
    pulse_btn();
    for (int k = 0; k < 5; k++) exp_q.push_back(n + 10 + 8 * k);
    goto(n + 2);
    total++; if (bus.state === 2'b00) passed++; else $display("FAIL run_not_yet: got %0d want 0", bus.state);
    goto(n + 3);
    total++; if (bus.state === 2'b01) passed++; else $display("FAIL run_entered: got %0d want 1", bus.state);
    total++; if (bus.count === 5'd7) passed++; else $display("FAIL run_first_count: got %0d want 7", bus.count);
    goto(n + 42);
    #1;
    total++; if (obs_q.size() == exp_q.size()) passed++; else $display("FAIL run01_strobes: got %0d want %0d", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o == e) passed++; else $display("FAIL run01_strobe_cycle: got %0d want %0d", o, e);
    end
    mon_en = 1'b0;
  endtask

  task automatic test_speed_00_11();
    int n, e, o;
    // speed 00: strobe on every RUN cycle
    do_reset(2'b00);
    n = cyc;
    pulse_btn();
    for (int k = 3; k <= 12; k++) exp_q.push_back(n + k);
    goto(n + 12);
    total++; if (bus.count === 5'd0) passed++; else $display("FAIL s00_count: got %0d want 0", bus.count);
    #1;
    total++; if (obs_q.size() == exp_q.size()) passed++; else $display("FAIL s00_strobes: got %0d want %0d", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o == e) passed++; else $display("FAIL s00_strobe_cycle: got %0d want %0d", o, e);
    end
    // speed 11: 32-cycle period
    do_reset(2'b11);
    n = cyc;
    pulse_btn();
    exp_q.push_back(n + 34); exp_q.push_back(n + 66);
    goto(n + 3);
    total++; if (bus.count === 5'd31) passed++; else $display("FAIL s11_first_count: got %0d want 31", bus.count);
    goto(n + 66);
    #1;
    total++; if (obs_q.size() == exp_q.size()) passed++; else $display("FAIL s11_strobes: got %0d want %0d", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o == e) passed++; else $display("FAIL s11_strobe_cycle: got %0d want %0d", o, e);
    end
    // 01 -> 11 mid-interval: current interval keeps its length
    do_reset(2'b01);
    n = cyc;
    pulse_btn();
    exp_q.push_back(n + 10); exp_q.push_back(n + 18);
    exp_q.push_back(n + 50); exp_q.push_back(n + 82);
    goto(n + 13);
    bus.speed = 2'b11;
    goto(n + 18);
    total++; if (bus.count === 5'd0) passed++; else $display("FAIL sw_old_interval: got %0d want 0", bus.count);
    goto(n + 19);
    total++; if (bus.count === 5'd31) passed++; else $display("FAIL sw_reload: got %0d want 31", bus.count);
    goto(n + 82);
    #1;
    total++; if (obs_q.size() == exp_q.size()) passed++; else $display("FAIL sw_strobes: got %0d want %0d", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o == e) passed++; else $display("FAIL sw_strobe_cycle: got %0d want %0d", o, e);
    end
    mon_en = 1'b0;
  endtask

  task automatic test_pause_resume();
    int n, e, o;
    do_reset(2'b01);
    n = cyc;
    pulse_btn();
    goto(n + 3);
    pulse_btn();
    goto(n + 6);
    total++; if (bus.state === 2'b10) passed++; else $display("FAIL pause_state: got %0d want 2", bus.state);
    total++; if (bus.count === 5'd4) passed++; else $display("FAIL pause_count: got %0d want 4", bus.count);
    goto(n + 26);
    total++; if (bus.count === 5'd4) passed++; else $display("FAIL pause_hold: got %0d want 4", bus.count);
    pulse_btn();
    exp_q.push_back(n + 33); exp_q.push_back(n + 41);
    goto(n + 28);
    total++; if (bus.state === 2'b10) passed++; else $display("FAIL pause_still: got %0d want 2", bus.state);
    goto(n + 29);
    total++; if (bus.state === 2'b01) passed++; else $display("FAIL resume_state: got %0d want 1", bus.state);
    total++; if (bus.count === 5'd4) passed++; else $display("FAIL resume_count: got %0d want 4", bus.count);
    goto(n + 41);
    #1;
    total++; if (obs_q.size() == exp_q.size()) passed++; else $display("FAIL pause_strobes: got %0d want %0d", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o == e) passed++; else $display("FAIL pause_strobe_cycle: got %0d want %0d", o, e);
    end
    mon_en = 1'b0;
  endtask

  task automatic test_edge_cases();
    int n, e, o;
    // clear and press together while running
    do_reset(2'b01);
    n = cyc;
    pulse_btn();
    goto(n + 3);
    pulse_btn();
    goto(n + 5);
    bus.clear = 1'b1;
    goto(n + 6);
    bus.clear = 1'b0;
    total++; if (bus.state === 2'b00) passed++; else $display("FAIL clr_press_state: got %0d want 0", bus.state);
    total++; if (bus.count === 5'd7) passed++; else $display("FAIL clr_press_count: got %0d want 7", bus.count);
    goto(n + 9);
    total++; if (bus.state === 2'b00) passed++; else $display("FAIL clr_press_stay: got %0d want 0", bus.state);
    // press coinciding with count==0
    do_reset(2'b01);
    n = cyc;
    pulse_btn();
    exp_q.push_back(n + 10);
    goto(n + 8);
    pulse_btn();
    goto(n + 10);
    total++; if (bus.enable_out === 1'b1) passed++; else $display("FAIL press0_strobe: got %0d want 1", bus.enable_out);
    goto(n + 11);
    total++; if (bus.state === 2'b10) passed++; else $display("FAIL press0_state: got %0d want 2", bus.state);
    total++; if (bus.count === 5'd7) passed++; else $display("FAIL press0_count: got %0d want 7", bus.count);
    goto(n + 20);
    total++; if (bus.count === 5'd7) passed++; else $display("FAIL press0_hold: got %0d want 7", bus.count);
    #1;
    total++; if (obs_q.size() == exp_q.size()) passed++; else $display("FAIL press0_strobes: got %0d want %0d", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o == e) passed++; else $display("FAIL press0_strobe_cycle: got %0d want %0d", o, e);
    end
    // clear coinciding with count==0
    do_reset(2'b01);
    n = cyc;
    pulse_btn();
    exp_q.push_back(n + 10);
    goto(n + 10);
    bus.clear = 1'b1;
    goto(n + 11);
    bus.clear = 1'b0;
    total++; if (bus.state === 2'b00) passed++; else $display("FAIL clr0_state: got %0d want 0", bus.state);
    total++; if (bus.count === 5'd7) passed++; else $display("FAIL clr0_count: got %0d want 7", bus.count);
    #1;
    total++; if (obs_q.size() == exp_q.size()) passed++; else $display("FAIL clr0_strobes: got %0d want %0d", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o == e) passed++; else $display("FAIL clr0_strobe_cycle: got %0d want %0d", o, e);
    end
    // held button: single transition, release ignored
    do_reset(2'b01);
    n = cyc;
    bus.run_btn = 1'b1;
    for (int k = 0; k < 7; k++) exp_q.push_back(n + 10 + 8 * k);
    goto(n + 50);
    bus.run_btn = 1'b0;
    goto(n + 60);
    total++; if (bus.state === 2'b01) passed++; else $display("FAIL hold_state: got %0d want 1", bus.state);
    total++; if (bus.count === 5'd6) passed++; else $display("FAIL hold_count: got %0d want 6", bus.count);
    #1;
    total++; if (obs_q.size() == exp_q.size()) passed++; else $display("FAIL hold_strobes: got %0d want %0d", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o == e) passed++; else $display("FAIL hold_strobe_cycle: got %0d want %0d", o, e);
    end
    mon_en = 1'b0;
  endtask

  task automatic test_async_reset();
    int n, e, o;
    do_reset(2'b01);
    n = cyc;
    pulse_btn();
    goto(n + 7);
    total++; if (bus.count === 5'd3) passed++; else $display("FAIL ar_pre_count: got %0d want 3", bus.count);
    #2 resetn = 1'b0;
    #1;
    total++; if (bus.state === 2'b00) passed++; else $display("FAIL ar_state: got %0d want 0", bus.state);
    total++; if (bus.count === 5'd0) passed++; else $display("FAIL ar_count: got %0d want 0", bus.count);
    total++; if (bus.enable_out === 1'b0) passed++; else $display("FAIL ar_enable: got %0d want 0", bus.enable_out);
    // reset while the strobe is high
    do_reset(2'b01);
    n = cyc;
    pulse_btn();
    exp_q.push_back(n + 10);
    goto(n + 10);
    total++; if (bus.enable_out === 1'b1) passed++; else $display("FAIL ar0_pre_enable: got %0d want 1", bus.enable_out);
    #2 resetn = 1'b0;
    #1;
    total++; if (bus.enable_out === 1'b0) passed++; else $display("FAIL ar0_enable: got %0d want 0", bus.enable_out);
    total++; if (bus.state === 2'b00) passed++; else $display("FAIL ar0_state: got %0d want 0", bus.state);
    total++; if (obs_q.size() == exp_q.size()) passed++; else $display("FAIL ar0_strobes: got %0d want %0d", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o == e) passed++; else $display("FAIL ar0_strobe_cycle: got %0d want %0d", o, e);
    end
    mon_en = 1'b0;
    resetn = 1'b1;
  endtask

  initial begin
    bus.speed   = 2'b00;
    bus.run_btn = 1'b0;
    bus.clear   = 1'b0;
    test_reset();
    test_run_speed01();
    test_speed_00_11();
    test_pause_resume();
    test_edge_cases();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
